parking_occupancy_ctrl: RTL and testbench

Multi-lane parking-lot occupancy controller: decodes vehicle direction from a two-sensor pair on each of LANES gates, and keeps a saturating occupancy count against a configurable capacity. Sits after the per-sensor debouncers and replaces the single-gate direction FSM plus fixed 3-bit up/down counter. Drives full/empty status and per-lane event pulses to the display and barrier logic.

---
 rtl/parking_pkg.sv | 29 ++
 rtl/lane_dir_fsm.sv | 86 ++++++++
 rtl/parking_occupancy_ctrl.sv | 101 ++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking occupancy controller.
// This file holds the lane state encoding, the normalised sensor codes and a popcount helper.
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IN1  = 3'd1,
    S_IN2  = 3'd2,
    S_IN3  = 3'd3,
    S_OUT1 = 3'd4,
    S_OUT2 = 3'd5,
    S_OUT3 = 3'd6,
    S_ERR  = 3'd7
  } lane_state_t;

  // ab = {outer, inner}, 1 = beam blocked
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lane_dir_fsm.sv
// Direction decoder for one gate's normalised sensor pair.
// The event outputs are combinational strobes for the edge that moves the state, so the top registers them alongside the count.
module lane_dir_fsm
  import parking_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] ab,
  output logic       entry,
  output logic       exit_evt,
  output logic       seq_error
);

  lane_state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    entry     = 1'b0;
    exit_evt  = 1'b0;
    seq_error = 1'b0;
    case (state_q)
      S_IDLE: begin
        if      (ab == AB_A)    state_d = S_IN1;
        else if (ab == AB_B)    state_d = S_OUT1;
        else if (ab == AB_BOTH) state_d = S_ERR;
      end
      S_IN1: begin
        if      (ab == AB_BOTH) state_d = S_IN2;
        else if (ab == AB_NONE) state_d = S_IDLE;
        else if (ab == AB_B)    state_d = S_ERR;
      end
      S_IN2: begin
        if      (ab == AB_B)    state_d = S_IN3;
        else if (ab == AB_A)    state_d = S_IN1;
        else if (ab == AB_NONE) state_d = S_IDLE;
      end
      S_IN3: begin
        if (ab == AB_NONE) begin
          state_d = S_IDLE;
          entry   = 1'b1;
        end
        else if (ab == AB_BOTH) state_d = S_IN2;
        else if (ab == AB_A)    state_d = S_ERR;
      end
      S_OUT1: begin
        if      (ab == AB_BOTH) state_d = S_OUT2;
        else if (ab == AB_NONE) state_d = S_IDLE;
        else if (ab == AB_A)    state_d = S_ERR;
      end
      S_OUT2: begin
        if      (ab == AB_A)    state_d = S_OUT3;
        else if (ab == AB_B)    state_d = S_OUT1;
        else if (ab == AB_NONE) state_d = S_IDLE;
      end
      S_OUT3: begin
        if (ab == AB_NONE) begin
          state_d  = S_IDLE;
          exit_evt = 1'b1;
        end
        else if (ab == AB_BOTH) state_d = S_OUT2;
        else if (ab == AB_B)    state_d = S_ERR;
      end
      S_ERR: begin
        if (ab == AB_NONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    seq_error = (state_d == S_ERR) && (state_q != S_ERR);

    // clear wins over anything the lane decoded this cycle
    if (clear) begin
      state_d   = S_IDLE;
      entry     = 1'b0;
      exit_evt  = 1'b0;
      seq_error = 1'b0;
    end
  end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-gate occupancy controller: per-lane direction decode feeding a saturating count.
// The count, the clamp pulses and the lane event pulses all register on the same edge.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int CAPACITY   = 7,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] sensor_a,
  input  logic [LANES-1:0] sensor_b,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] entry_pulse,
  output logic [LANES-1:0] exit_pulse,
  output logic [LANES-1:0] seq_error,
  output logic             overflow,
  output logic             underflow
);

  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [LANES-1:0][1:0] ab;
  logic [LANES-1:0]      ent_ev, ext_ev, err_ev;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ab[i] = ACTIVE_LOW ? ~{sensor_a[i], sensor_b[i]} : {sensor_a[i], sensor_b[i]};

    lane_dir_fsm u_fsm (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .ab       (ab[i]),
      .entry    (ent_ev[i]),
      .exit_evt (ext_ev[i]),
      .seq_error(err_ev[i])
    );
  end

  logic [CNT_W-1:0]     count_q, count_d;
  logic [LANES-1:0]     ent_q, ext_q, err_q;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic [3:0]           n_in, n_out;
  logic signed [SW-1:0] sum;

  always_comb begin
    n_in    = popcount8(8'(ent_ev));
    n_out   = popcount8(8'(ext_ev));
    sum     = $signed(SW'(count_q)) + $signed(SW'(n_in)) - $signed(SW'(n_out));
    count_d = sum[CNT_W-1:0];
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clear) begin
      count_d = '0;
    end
    else if (sum[SW-1]) begin
      count_d = '0;
      unf_d   = 1'b1;
    end
    else if (sum > CAP_S) begin
      count_d = CNT_W'(CAPACITY);
      ovf_d   = 1'b1;
    end
  end

  // lane strobes are already masked by clear inside each FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ent_q   <= '0;
      ext_q   <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end
    else begin
      count_q <= count_d;
      ent_q   <= ent_ev;
      ext_q   <= ext_ev;
      err_q   <= err_ev;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count       = count_q;
  assign full        = (count_q == CNT_W'(CAPACITY));
  assign empty       = (count_q == '0);
  assign entry_pulse = ent_q;
  assign exit_pulse  = ext_q;
  assign seq_error   = err_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs from a path-walking reference model,
// and a monitor pops and compares one entry per clock.
module tb_parking_occupancy_ctrl;
  localparam int LANES    = 2;
  localparam int CAPACITY = 7;
  localparam int CNT_W    = $clog2(CAPACITY + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic [LANES-1:0] sensor_a = '1;
  logic [LANES-1:0] sensor_b = '1;
  logic [CNT_W-1:0] count;
  logic             full, empty, overflow, underflow;
  logic [LANES-1:0] entry_pulse, exit_pulse, seq_error;

  parking_occupancy_ctrl #(.LANES(LANES), .CAPACITY(CAPACITY), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b), .clear(clear),
    .count(count), .full(full), .empty(empty), .entry_pulse(entry_pulse),
    .exit_pulse(exit_pulse), .seq_error(seq_error), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0] ent, ext, serr;
    logic             ovf, unf;
    logic [CNT_W-1:0] cnt;
    logic             full, empty;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0, n_fail = 0;

  // Legal walks: index 0 is idle (00); walking forward past index 3 completes a passage.
  logic [1:0] PATH [2][4] = '{'{2'b00, 2'b10, 2'b11, 2'b01}, '{2'b00, 2'b01, 2'b11, 2'b10}};
  int m_dir [LANES];
  int m_idx [LANES];
  bit m_err [LANES];
  int m_cnt;

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_dir[l] = 0; m_idx[l] = 0; m_err[l] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [LANES-1:0][1:0] ab, input bit clr, output obs_t o);
    int nin, nout, d, i;
    logic [1:0] v;
    o = '0; nin = 0; nout = 0;
    if (clr) model_reset();
    else begin
      for (int l = 0; l < LANES; l++) begin
        v = ab[l]; d = m_dir[l]; i = m_idx[l];
        if (m_err[l]) begin
          if (v == 2'b00) m_err[l] = 1'b0;
        end
        else if (v == PATH[d][i]) begin
        end
        else if (i == 0) begin
          if (v == PATH[0][1])      begin m_dir[l] = 0; m_idx[l] = 1; end
          else if (v == PATH[1][1]) begin m_dir[l] = 1; m_idx[l] = 1; end
          else begin m_err[l] = 1'b1; o.serr[l] = 1'b1; end
        end
        else if (v == 2'b00) begin
          if (i == 3) begin
            if (d == 0) begin o.ent[l] = 1'b1; nin++; end
            else        begin o.ext[l] = 1'b1; nout++; end
          end
          m_idx[l] = 0;
        end
        else if (i < 3 && v == PATH[d][i+1]) m_idx[l] = i + 1;
        else if (v == PATH[d][i-1])          m_idx[l] = i - 1;
        else begin m_err[l] = 1'b1; m_idx[l] = 0; o.serr[l] = 1'b1; end
      end
      m_cnt = m_cnt + nin - nout;
      if (m_cnt > CAPACITY) begin m_cnt = CAPACITY; o.ovf = 1'b1; end
      else if (m_cnt < 0)   begin m_cnt = 0;        o.unf = 1'b1; end
    end
    o.cnt   = CNT_W'(m_cnt);
    o.full  = (m_cnt == CAPACITY);
    o.empty = (m_cnt == 0);
  endtask

  task automatic step(input logic [LANES-1:0][1:0] ab, input bit clr);
    obs_t o;
    @(negedge clk);
    for (int l = 0; l < LANES; l++) begin
      sensor_a[l] = ~ab[l][1];
      sensor_b[l] = ~ab[l][0];
    end
    clear = clr;
    model_step(ab, clr, o);
    exp_q.push_back(o);
  endtask

  task automatic pass_lane(input int lane, input int dir);
    logic [LANES-1:0][1:0] ab;
    for (int k = 1; k <= 4; k++) begin
      ab = '0;
      ab[lane] = PATH[dir][k % 4];
      step(ab, 1'b0);
    end
  endtask

  task automatic check_reset(input string name);
    n_chk++;
    if (count !== '0 || full !== 1'b0 || empty !== 1'b1 || entry_pulse !== '0 ||
        exit_pulse !== '0 || seq_error !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: count=%0d full=%b empty=%b ent=%b ext=%b serr=%b ovf=%b unf=%b, required count=0 full=0 empty=1 pulses=0",
               name, count, full, empty, entry_pulse, exit_pulse, seq_error, overflow, underflow);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ent: entry_pulse, ext: exit_pulse, serr: seq_error, ovf: overflow, unf: underflow,
              cnt: count, full: full, empty: empty};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got ent=%b ext=%b serr=%b ovf=%b unf=%b cnt=%0d full=%b empty=%b, required ent=%b ext=%b serr=%b ovf=%b unf=%b cnt=%0d full=%b empty=%b",
                   $time, a.ent, a.ext, a.serr, a.ovf, a.unf, a.cnt, a.full, a.empty,
                   e.ent, e.ext, e.serr, e.ovf, e.unf, e.cnt, e.full, e.empty);
        end
      end
    end
  end

  initial begin : stim
    logic [LANES-1:0][1:0] ab;
    logic [1:0] cur;
    int r, pref, bias;
    model_reset();
    #3 check_reset("reset_state");
    @(negedge clk); reset = 1'b1;

    // entry on lane 0, then backtrack-and-abort on lane 1
    step({2'b00, 2'b00}, 1'b0);
    pass_lane(0, 0);
    step({2'b10, 2'b00}, 1'b0);
    step({2'b11, 2'b00}, 1'b0);
    step({2'b10, 2'b00}, 1'b0);
    step({2'b00, 2'b00}, 1'b0);
    // fill to capacity, then one more entry clamps
    for (int k = 0; k < 7; k++) pass_lane(0, 0);
    // drain to 3, then simultaneous entry (lane 0) and exit (lane 1)
    for (int k = 0; k < 4; k++) pass_lane(1, 1);
    step({2'b01, 2'b10}, 1'b0);
    step({2'b11, 2'b11}, 1'b0);
    step({2'b10, 2'b01}, 1'b0);
    step({2'b00, 2'b00}, 1'b0);
    // illegal jump on lane 0, held in error until idle, then a clean entry
    step({2'b00, 2'b10}, 1'b0);
    step({2'b00, 2'b01}, 1'b0);
    step({2'b00, 2'b11}, 1'b0);
    step({2'b00, 2'b00}, 1'b0);
    pass_lane(0, 0);
    // underflow: exits past zero
    for (int k = 0; k < 6; k++) pass_lane(1, 1);
    for (int k = 0; k < 5; k++) pass_lane(0, 0);
    // clear mid-exit at count 5, then the tail of the exit
    step({2'b01, 2'b00}, 1'b0);
    step({2'b11, 2'b00}, 1'b0);
    step({2'b11, 2'b00}, 1'b1);
    step({2'b10, 2'b00}, 1'b0);
    step({2'b00, 2'b00}, 1'b0);
    pass_lane(0, 0);
    step({2'b00, 2'b10}, 1'b0);
    step({2'b00, 2'b11}, 1'b0);
    // asynchronous reset between edges
    #2 reset = 1'b0;
    exp_q.delete();
    model_reset();
    #1 check_reset("async_reset");
    @(posedge clk); #1 check_reset("reset_held");
    @(negedge clk); reset = 1'b1;

    // randomized walks biased toward entries first, exits later
    for (int c = 0; c < 600; c++) begin
      bias = (c < 300) ? 0 : 1;
      for (int l = 0; l < LANES; l++) begin
        r   = $urandom_range(0, 19);
        cur = m_err[l] ? 2'b00 : PATH[m_dir[l]][m_idx[l]];
        pref = ($urandom_range(0, 3) == 0) ? 1 - bias : bias;
        if (m_err[l])           ab[l] = (r < 12) ? 2'b00 : 2'($urandom);
        else if (m_idx[l] == 0) ab[l] = (r < 14) ? PATH[pref][1] : (r < 18) ? 2'b00 : 2'($urandom);
        else if (r < 10)        ab[l] = PATH[m_dir[l]][(m_idx[l] + 1) % 4];
        else if (r < 13)        ab[l] = PATH[m_dir[l]][m_idx[l] - 1];
        else if (r < 16)        ab[l] = cur;
        else if (r < 18)        ab[l] = 2'b00;
        else                    ab[l] = 2'($urandom);
      end
      step(ab, ($urandom_range(0, 59) == 0));
    end
    step('0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
